// File: rtl/chip8_fetch.sv
`timescale 1ns/1ps
// CHIP-8 instruction fetch: reads two big-endian opcode bytes from byte-wide
// program memory, presents the opcode on a valid/ready handshake and owns the pc.
module chip8_fetch #(
    parameter logic [11:0] RESET_PC    = 12'h200,
    parameter int unsigned MEM_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_en,
    output logic [11:0] mem_addr,
    output logic        mem_rd,
    input  logic [7:0]  mem_rdata,
    output logic [15:0] opcode,
    output logic        opcode_valid,
    input  logic        opcode_ready,
    output logic [11:0] pc,
    input  logic        pc_jump,
    input  logic [11:0] jump_target,
    input  logic        pc_skip
);

    typedef enum logic [2:0] {
        HI_REQ,
        HI_WAIT,
        LO_REQ,
        LO_WAIT,
        VALID
    } state_t;

    localparam logic [1:0] LAT = 2'(MEM_LATENCY);

    state_t      state;
    logic [1:0]  wait_cnt;
    logic [11:0] addr_hold;
    logic [11:0] rd_addr;
    logic [11:0] next_pc;
    logic        issue;

    // The read strobe is combinational from the request states so the read
    // leaves in the same cycle fetch_en is seen; reset masks it immediately.
    always_comb begin
        issue   = 1'b0;
        rd_addr = pc;
        case (state)
            HI_REQ: issue = fetch_en;
            LO_REQ: begin
                issue   = 1'b1;
                rd_addr = pc + 12'd1;
            end
            default: ;
        endcase
        issue = issue & ~reset;
    end

    assign mem_rd   = issue;
    assign mem_addr = issue ? rd_addr : addr_hold;

    always_comb begin
        if (pc_jump)
            next_pc = jump_target;
        else if (pc_skip)
            next_pc = pc + 12'd4;
        else
            next_pc = pc + 12'd2;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= HI_REQ;
            pc           <= RESET_PC;
            addr_hold    <= RESET_PC;
            opcode       <= '0;
            opcode_valid <= 1'b0;
            wait_cnt     <= '0;
        end else begin
            if (issue)
                addr_hold <= rd_addr;
            case (state)
                HI_REQ: begin
                    if (fetch_en) begin
                        wait_cnt <= LAT;
                        state    <= HI_WAIT;
                    end
                end
                HI_WAIT: begin
                    if (wait_cnt == 2'd1) begin
                        opcode[15:8] <= mem_rdata;
                        wait_cnt     <= '0;
                        state        <= LO_REQ;
                    end else begin
                        wait_cnt <= wait_cnt - 2'd1;
                    end
                end
                LO_REQ: begin
                    wait_cnt <= LAT;
                    state    <= LO_WAIT;
                end
                LO_WAIT: begin
                    if (wait_cnt == 2'd1) begin
                        opcode[7:0]  <= mem_rdata;
                        wait_cnt     <= '0;
                        opcode_valid <= 1'b1;
                        state        <= VALID;
                    end else begin
                        wait_cnt <= wait_cnt - 2'd1;
                    end
                end
                VALID: begin
                    if (opcode_ready) begin
                        opcode_valid <= 1'b0;
                        pc           <= next_pc;
                        state        <= HI_REQ;
                    end
                end
                default: state <= HI_REQ;
            endcase
        end
    end

endmodule

// File: tb/tb_chip8_fetch.sv
`timescale 1ns/1ps
// Bench for chip8_fetch: a latency-1 and a latency-3 instance share one program
// memory; expectations come from the opcode/pc rules applied to that memory.
module tb_chip8_fetch;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset;

    logic        fetch_en1, mem_rd1, opcode_valid1, opcode_ready1, pc_jump1, pc_skip1;
    logic [11:0] mem_addr1, pc1, jump_target1;
    logic [7:0]  mem_rdata1;
    logic [15:0] opcode1;

    logic        fetch_en3, mem_rd3, opcode_valid3, opcode_ready3, pc_jump3, pc_skip3;
    logic [11:0] mem_addr3, pc3, jump_target3;
    logic [7:0]  mem_rdata3;
    logic [15:0] opcode3;

    logic [7:0] mem [0:4095];
    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int rd_addr_q[$];
    int rd_cyc_q[$];
    int mpc;

    chip8_fetch #(.RESET_PC(12'h200), .MEM_LATENCY(1)) dut1 (
        .clk(clk), .reset(reset), .fetch_en(fetch_en1), .mem_addr(mem_addr1),
        .mem_rd(mem_rd1), .mem_rdata(mem_rdata1), .opcode(opcode1),
        .opcode_valid(opcode_valid1), .opcode_ready(opcode_ready1), .pc(pc1),
        .pc_jump(pc_jump1), .jump_target(jump_target1), .pc_skip(pc_skip1)
    );

    chip8_fetch #(.RESET_PC(12'h200), .MEM_LATENCY(3)) dut3 (
        .clk(clk), .reset(reset), .fetch_en(fetch_en3), .mem_addr(mem_addr3),
        .mem_rd(mem_rd3), .mem_rdata(mem_rdata3), .opcode(opcode3),
        .opcode_valid(opcode_valid3), .opcode_ready(opcode_ready3), .pc(pc3),
        .pc_jump(pc_jump3), .jump_target(jump_target3), .pc_skip(pc_skip3)
    );

    // memory models: data is only valid exactly LATENCY cycles after the strobe
    logic        v1;
    logic [11:0] a1;
    always @(posedge clk) begin
        v1 <= mem_rd1;
        a1 <= mem_addr1;
    end
    assign mem_rdata1 = v1 ? mem[a1] : 8'hC3;

    logic        v3_0, v3_1, v3_2;
    logic [11:0] a3_0, a3_1, a3_2;
    always @(posedge clk) begin
        v3_0 <= mem_rd3;  a3_0 <= mem_addr3;
        v3_1 <= v3_0;     a3_1 <= a3_0;
        v3_2 <= v3_1;     a3_2 <= a3_1;
    end
    assign mem_rdata3 = v3_2 ? mem[a3_2] : 8'hC3;

    always @(posedge clk) begin
        if (mem_rd1 === 1'b1) begin
            rd_addr_q.push_back(int'(mem_addr1));
            rd_cyc_q.push_back(cyc);
        end
        cyc <= cyc + 1;
    end

    function automatic int nxt(input int p, input bit j, input bit s, input int t);
        if (j) return t % 4096;
        if (s) return (p + 4) % 4096;
        return (p + 2) % 4096;
    endfunction

    function automatic logic [15:0] exp_op(input int p);
        return {mem[12'(p)], mem[12'(p + 1)]};
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_q();
        rd_addr_q.delete();
        rd_cyc_q.delete();
    endtask

    task automatic accept1(input bit j, input bit s, input logic [11:0] t);
        opcode_ready1 = 1'b1;
        pc_jump1 = j;
        pc_skip1 = s;
        jump_target1 = t;
        tick();
        opcode_ready1 = 1'b0;
        pc_jump1 = 1'($urandom);
        pc_skip1 = 1'($urandom);
        jump_target1 = 12'($urandom);
    endtask

    task automatic wait_valid1(input int limit, input bit scramble, output int vcyc, output bit ok);
        ok = 1'b0;
        vcyc = -1;
        for (int i = 0; i < limit; i++) begin
            if (opcode_valid1 === 1'b1) begin
                ok = 1'b1;
                vcyc = cyc;
                break;
            end
            if (scramble && i > 0) fetch_en1 = 1'($urandom);
            tick();
        end
    endtask

    task automatic test_reset();
        int t0;
        fetch_en1 = 1'b1;
        opcode_ready1 = 1'b0;
        reset = 1'b1;
        mem[12'h200] = 8'h00;
        mem[12'h201] = 8'hE0;
        tick();
        tick();
        checks++; if (pc1 !== 12'h200) begin failures++; $display("FAIL rst_pc got %h want 200", pc1); end
        checks++; if (opcode1 !== 16'h0000) begin failures++; $display("FAIL rst_opcode got %h want 0000", opcode1); end
        checks++; if (opcode_valid1 !== 1'b0) begin failures++; $display("FAIL rst_valid got %b want 0", opcode_valid1); end
        checks++; if (mem_rd1 !== 1'b0) begin failures++; $display("FAIL rst_mem_rd got %b want 0", mem_rd1); end
        checks++; if (mem_addr1 !== 12'h200) begin failures++; $display("FAIL rst_mem_addr got %h want 200", mem_addr1); end
        @(negedge clk);
        reset = 1'b0;
        t0 = cyc;
        clear_q();
        #1;
        for (int k = 0; k <= 4; k++) begin
            if (k > 0) tick();
            checks++;
            if (mem_rd1 !== 1'((k == 0) || (k == 2))) begin
                failures++; $display("FAIL t1_mem_rd k=%0d got %b want %b", k, mem_rd1, (k == 0) || (k == 2));
            end
            checks++;
            if (opcode_valid1 !== 1'(k == 4)) begin
                failures++; $display("FAIL t1_valid k=%0d got %b want %b", k, opcode_valid1, k == 4);
            end
        end
        checks++; if (opcode1 !== 16'h00E0) begin failures++; $display("FAIL t1_opcode got %h want 00e0", opcode1); end
        checks++; if (pc1 !== 12'h200) begin failures++; $display("FAIL t1_pc got %h want 200", pc1); end
        checks++;
        if (rd_addr_q.size() != 2 || rd_addr_q[0] != 'h200 || rd_addr_q[1] != 'h201 ||
            rd_cyc_q[0] != t0 || rd_cyc_q[1] != t0 + 2) begin
            failures++; $display("FAIL t1_reads got n=%0d want 200@0,201@2", rd_addr_q.size());
        end
        mpc = 'h200;
    endtask

    task automatic test_accept_controls();
        bit jv[3] = '{1'b0, 1'b0, 1'b1};
        bit sv[3] = '{1'b0, 1'b1, 1'b1};
        logic [11:0] tv[3];
        int a, v;
        bit ok;
        tv[0] = 12'($urandom);
        tv[1] = 12'($urandom);
        tv[2] = 12'h3A5;
        fetch_en1 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a = cyc;
            accept1(jv[i], sv[i], tv[i]);
            mpc = nxt(mpc, jv[i], sv[i], int'(tv[i]));
            checks++; if (opcode_valid1 !== 1'b0) begin failures++; $display("FAIL t2_valid_drop i=%0d got %b want 0", i, opcode_valid1); end
            checks++; if (pc1 !== 12'(mpc)) begin failures++; $display("FAIL t2_pc i=%0d got %h want %h", i, pc1, 12'(mpc)); end
            checks++; if (mem_rd1 !== 1'b1 || mem_addr1 !== 12'(mpc)) begin
                failures++; $display("FAIL t2_issue i=%0d got rd=%b addr=%h want rd=1 addr=%h", i, mem_rd1, mem_addr1, 12'(mpc));
            end
            wait_valid1(20, 1'b0, v, ok);
            checks++; if (!ok || v - a != 5) begin failures++; $display("FAIL t2_latency i=%0d got %0d want 5", i, v - a); end
            checks++; if (opcode1 !== exp_op(mpc)) begin failures++; $display("FAIL t2_opcode i=%0d got %h want %h", i, opcode1, exp_op(mpc)); end
        end
    endtask

    task automatic test_hold();
        int v;
        bit ok;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (opcode_valid1 !== 1'b1 || pc1 !== 12'(mpc) || opcode1 !== exp_op(mpc) || mem_rd1 !== 1'b0) begin
                failures++;
                $display("FAIL t3_hold i=%0d got v=%b pc=%h op=%h rd=%b want v=1 pc=%h op=%h rd=0",
                         i, opcode_valid1, pc1, opcode1, mem_rd1, 12'(mpc), exp_op(mpc));
            end
            tick();
        end
        accept1(1'b0, 1'b0, 12'($urandom));
        mpc = nxt(mpc, 1'b0, 1'b0, 0);
        checks++; if (opcode_valid1 !== 1'b0) begin failures++; $display("FAIL t3_valid_drop got %b want 0", opcode_valid1); end
        wait_valid1(20, 1'b0, v, ok);
        checks++; if (!ok) begin failures++; $display("FAIL t3_refetch got timeout want valid"); end
    endtask

    task automatic test_wrap();
        int v;
        bit ok;
        mem[12'hFFF] = 8'h12;
        mem[12'h000] = 8'h34;
        fetch_en1 = 1'b1;
        accept1(1'b1, 1'b0, 12'hFFF);
        clear_q();
        checks++; if (pc1 !== 12'hFFF) begin failures++; $display("FAIL t4_pc_jump got %h want fff", pc1); end
        wait_valid1(20, 1'b0, v, ok);
        checks++; if (!ok || opcode1 !== 16'h1234) begin failures++; $display("FAIL t4_opcode got %h want 1234", opcode1); end
        checks++;
        if (rd_addr_q.size() != 2 || rd_addr_q[0] != 'hFFF || rd_addr_q[1] != 'h000) begin
            failures++; $display("FAIL t4_reads got n=%0d want fff,000", rd_addr_q.size());
        end
        accept1(1'b0, 1'b0, 12'($urandom));
        checks++; if (pc1 !== 12'h001) begin failures++; $display("FAIL t4_pc_wrap got %h want 001", pc1); end
        wait_valid1(20, 1'b0, v, ok);
        accept1(1'b1, 1'b0, 12'hFFE);
        wait_valid1(20, 1'b0, v, ok);
        checks++; if (!ok || opcode1 !== exp_op('hFFE)) begin failures++; $display("FAIL t4_opcode_ffe got %h want %h", opcode1, exp_op('hFFE)); end
        accept1(1'b0, 1'b1, 12'($urandom));
        checks++; if (pc1 !== 12'h002) begin failures++; $display("FAIL t4_skip_wrap got %h want 002", pc1); end
        wait_valid1(20, 1'b0, v, ok);
        checks++; if (!ok || opcode1 !== exp_op(2)) begin failures++; $display("FAIL t4_opcode_002 got %h want %h", opcode1, exp_op(2)); end
        mpc = 2;
    endtask

    task automatic test_fetch_en_and_reset();
        int a, v;
        bit ok;
        fetch_en1 = 1'b0;
        reset = 1'b1;
        tick();
        @(negedge clk);
        reset = 1'b0;
        clear_q();
        #1;
        for (int i = 0; i < 20; i++) begin
            checks++;
            if (mem_rd1 !== 1'b0 || opcode_valid1 !== 1'b0) begin
                failures++; $display("FAIL t5_idle i=%0d got rd=%b v=%b want 0 0", i, mem_rd1, opcode_valid1);
            end
            tick();
        end
        checks++; if (rd_addr_q.size() != 0) begin failures++; $display("FAIL t5_no_reads got %0d want 0", rd_addr_q.size()); end
        fetch_en1 = 1'b1;
        #1;
        checks++; if (mem_rd1 !== 1'b1 || mem_addr1 !== 12'h200) begin failures++; $display("FAIL t5_issue got rd=%b addr=%h want 1 200", mem_rd1, mem_addr1); end
        a = cyc;
        wait_valid1(20, 1'b0, v, ok);
        checks++; if (!ok || v - a != 4) begin failures++; $display("FAIL t5_latency got %0d want 4", v - a); end
        checks++; if (opcode1 !== exp_op('h200)) begin failures++; $display("FAIL t5_opcode got %h want %h", opcode1, exp_op('h200)); end
        accept1(1'b0, 1'b0, 12'($urandom));
        tick();
        tick();
        checks++; if (mem_rd1 !== 1'b1 || mem_addr1 !== 12'h203) begin failures++; $display("FAIL t5_lo_req got rd=%b addr=%h want 1 203", mem_rd1, mem_addr1); end
        tick();
        reset = 1'b1;
        #1;
        checks++;
        if (mem_rd1 !== 1'b0 || opcode_valid1 !== 1'b0 || pc1 !== 12'h200 || mem_addr1 !== 12'h200) begin
            failures++; $display("FAIL t5_mid_reset got rd=%b v=%b pc=%h addr=%h want 0 0 200 200", mem_rd1, opcode_valid1, pc1, mem_addr1);
        end
        @(negedge clk);
        reset = 1'b0;
        a = cyc;
        clear_q();
        #1;
        checks++; if (mem_rd1 !== 1'b1 || mem_addr1 !== 12'h200) begin failures++; $display("FAIL t5_refetch_issue got rd=%b addr=%h want 1 200", mem_rd1, mem_addr1); end
        wait_valid1(20, 1'b0, v, ok);
        checks++; if (!ok || v - a != 4 || opcode1 !== exp_op('h200)) begin
            failures++; $display("FAIL t5_refetch got lat=%0d op=%h want 4 %h", v - a, opcode1, exp_op('h200));
        end
        checks++;
        if (rd_addr_q.size() != 2 || rd_addr_q[0] != 'h200 || rd_addr_q[1] != 'h201) begin
            failures++; $display("FAIL t5_refetch_reads got n=%0d want 200,201", rd_addr_q.size());
        end
        mpc = 'h200;
    endtask

    task automatic test_random_stream();
        int a, v, d, gap, last_addr;
        bit j, s, ok;
        logic [11:0] t;
        for (int n = 0; n < 40; n++) begin
            d = $urandom_range(0, 3);
            for (int i = 0; i < d; i++) begin
                checks++;
                if (opcode_valid1 !== 1'b1 || pc1 !== 12'(mpc)) begin
                    failures++; $display("FAIL rs_wait n=%0d got v=%b pc=%h want 1 %h", n, opcode_valid1, pc1, 12'(mpc));
                end
                tick();
            end
            j = ($urandom_range(0, 3) == 0);
            s = 1'($urandom);
            t = 12'($urandom);
            gap = $urandom_range(0, 2);
            fetch_en1 = (gap == 0);
            last_addr = (mpc + 1) % 4096;
            accept1(j, s, t);
            mpc = nxt(mpc, j, s, int'(t));
            checks++;
            if (opcode_valid1 !== 1'b0 || pc1 !== 12'(mpc)) begin
                failures++; $display("FAIL rs_accept n=%0d got v=%b pc=%h want 0 %h", n, opcode_valid1, pc1, 12'(mpc));
            end
            for (int g = 0; g < gap; g++) begin
                checks++;
                if (mem_rd1 !== 1'b0 || mem_addr1 !== 12'(last_addr)) begin
                    failures++; $display("FAIL rs_gap n=%0d got rd=%b addr=%h want 0 %h", n, mem_rd1, mem_addr1, 12'(last_addr));
                end
                tick();
            end
            fetch_en1 = 1'b1;
            #1;
            checks++;
            if (mem_rd1 !== 1'b1 || mem_addr1 !== 12'(mpc)) begin
                failures++; $display("FAIL rs_issue n=%0d got rd=%b addr=%h want 1 %h", n, mem_rd1, mem_addr1, 12'(mpc));
            end
            a = cyc;
            wait_valid1(20, 1'b1, v, ok);
            checks++; if (!ok || v - a != 4) begin failures++; $display("FAIL rs_latency n=%0d got %0d want 4", n, v - a); end
            checks++; if (opcode1 !== exp_op(mpc)) begin failures++; $display("FAIL rs_opcode n=%0d got %h want %h", n, opcode1, exp_op(mpc)); end
        end
    endtask

    task automatic test_back_to_back();
        int m3, ph;
        bit j, s, exp_rd, exp_v;
        logic [11:0] t;
        fetch_en3 = 1'b1;
        opcode_ready3 = 1'b1;
        reset = 1'b1;
        tick();
        @(negedge clk);
        reset = 1'b0;
        m3 = 'h200;
        for (int k = 0; k < 81; k++) begin
            if (k > 0) tick();
            j = ($urandom_range(0, 3) == 0);
            s = 1'($urandom);
            t = 12'($urandom);
            pc_jump3 = j;
            pc_skip3 = s;
            jump_target3 = t;
            #1;
            ph = k % 9;
            exp_rd = (ph == 0) || (ph == 4);
            exp_v = (ph == 8);
            checks++; if (mem_rd3 !== exp_rd) begin failures++; $display("FAIL b2b_mem_rd k=%0d got %b want %b", k, mem_rd3, exp_rd); end
            if (exp_rd) begin
                checks++;
                if (mem_addr3 !== 12'(ph == 0 ? m3 : m3 + 1)) begin
                    failures++; $display("FAIL b2b_addr k=%0d got %h want %h", k, mem_addr3, 12'(ph == 0 ? m3 : m3 + 1));
                end
            end
            checks++; if (opcode_valid3 !== exp_v) begin failures++; $display("FAIL b2b_valid k=%0d got %b want %b", k, opcode_valid3, exp_v); end
            if (exp_v) begin
                checks++;
                if (opcode3 !== exp_op(m3) || pc3 !== 12'(m3)) begin
                    failures++; $display("FAIL b2b_opcode k=%0d got %h pc=%h want %h pc=%h", k, opcode3, pc3, exp_op(m3), 12'(m3));
                end
                m3 = nxt(m3, j, s, int'(t));
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        fetch_en1 = 1'b0; opcode_ready1 = 1'b0; pc_jump1 = 1'b0; pc_skip1 = 1'b0; jump_target1 = '0;
        fetch_en3 = 1'b0; opcode_ready3 = 1'b0; pc_jump3 = 1'b0; pc_skip3 = 1'b0; jump_target3 = '0;
        for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
        test_reset();
        test_accept_controls();
        test_hold();
        test_wrap();
        test_fetch_en_and_reset();
        test_random_stream();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
